wishbone_arbiter2: RTL and testbench
====================================

Name: wishbone_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter that shares a single slave (an output register or null slave) between two bus masters.
- Round-robin grant is held for a whole bus cycle, i.e. while the owner keeps cyc high.
- A bus watchdog terminates stalled transfers with err.
- Sits between the masters and the slave in the top-level interconnect.

Parameters:
- TIMEOUT, 16, cycles an owner strobe may wait for ack/err/rty before the arbiter forces err; 0 disables the watchdog.
- CNT_WIDTH, oitBits(TIMEOUT+1), width of the watchdog counter.

Ports:
- clk_i  input  1  bus clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0  interface  wishboneSlave.slave  master 0 side, higher priority on the first tie after reset.
- m1  interface  wishboneSlave.slave  master 1 side.
- s  interface  wishboneSlave.master  shared slave side.
- gnt  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = idle).

Behaviour:
- State: IDLE, OWN0, OWN1. Registers: state, last (the last owner served), wdog counter.
- Reset (reset_n low, asynchronous):
  - state=IDLE, last=1, wdog=0.
  - s.cyc_o=s.stb_o=0; all master ack/err/rty=0; gnt=00.
- IDLE:
  - Only m0.cyc_i -> OWN0. Only m1.cyc_i -> OWN1.
  - Both -> the master that is not `last`.
  - Grant takes effect next cycle: one cycle of arbitration latency, and no forwarding in IDLE.
- OWN0/OWN1 forwarding (combinational from owner to s): cyc, stb, we, adr, sel, dat, tgd.
  - Owner receives s.ack/err/rty/dat/tgd.
  - Non-owner sees ack=err=rty=0, dat_o=0, tgd_o=0.
- Release: owner drops cyc_i -> last<=owner. Then:
  - If the other master's cyc_i is high, go directly to the other OWN state (no dead cycle).
  - Else go to IDLE.
  - The same owner cannot be re-granted while the other is requesting.
- The owner keeping cyc_i high holds the grant indefinitely (locked multi-beat cycles). The non-owner waits with no ack.
- Watchdog (only if TIMEOUT>0):
  - wdog increments each cycle that owner cyc&stb=1 and s.ack|err|rty=0.
  - wdog clears on any slave termination, on stb low, or on an ownership change.
  - When wdog==TIMEOUT-1 and still unterminated: that cycle the owner gets err=1 (ack/rty forced 0) and s.stb_o forced 0. wdog clears.
  - Owner remains granted until it drops cyc.
- Simultaneous events:
  - Slave ack on the same cycle as a watchdog expiry: the slave ack wins and no err is issued.
  - Request arriving in the same cycle as release: handled by the Release rule.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs deasserted, independent of clk_i.
- gnt is decoded from state (registered, glitch-free).

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t.
  - Function next_owner(req0, req1, last).
  - Constant ARB_NUM_MASTERS=2.
- Sub-module wb_watchdog (TIMEOUT, CNT_WIDTH):
  - Inputs: clk_i, reset_n, clear, pending.
  - Output: expire (one-cycle pulse).
- Mux/steering logic stays in the top module.

Test Plan:
1. Reset: hold reset_n=0 with both cyc_i=1 -> gnt=00, s.cyc_o=0, no ack. Release reset -> gnt=01 after one clock; m0 write 0x000000A5 mode 0 lands in the slave.
2. Tie round-robin: both masters hold cyc for 3 single-beat cycles each, dropping cyc after ack.
   - Grant sequence is m0, m1, m0, m1 with no IDLE cycles between handovers.
   - Non-owner ack stays 0 throughout.
3. Locked burst: m1 owns and issues 4 strobes with cyc held while m0 requests.
   - gnt stays 10 for all 4 acks.
   - gnt switches to 01 the cycle after m1 drops cyc.
4. Watchdog: TIMEOUT=4, slave never acks.
   - Owner sees err=1 exactly on the 4th cycle of stb; s.stb_o=0 that cycle; ack=0.
   - With TIMEOUT=0 the same stimulus waits indefinitely.
5. Ack and expiry collide: slave acks in the expiry cycle -> owner gets ack=1, err=0, and wdog is cleared.
6. Async reset mid-transfer: pull reset_n low between clock edges during an m0 write -> s.cyc_o drops immediately and state=IDLE. The slave register is not written on that cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
// Provides the arbiter state encoding, the Wishbone request/response payloads
// and the round-robin owner selection used when leaving IDLE.
package wb_arb_pkg;

  localparam int unsigned ARB_NUM_MASTERS = 2;
  localparam int unsigned WB_ADR_W        = 32;
  localparam int unsigned WB_DAT_W        = 32;
  localparam int unsigned WB_SEL_W        = WB_DAT_W / 8;
  localparam int unsigned WB_TGD_W        = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

  // Master-to-slave signals (cyc/stb/we/adr/sel/dat_o/tgd_o).
  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_TGD_W-1:0] tgd;
  } wb_req_t;

  // Slave-to-master signals (ack/err/rty/dat_i/tgd_i).
  typedef struct packed {
    logic                ack;
    logic                err;
    logic                rty;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_TGD_W-1:0] tgd;
  } wb_rsp_t;

  // On a tie the master that was not served last wins; last=1 means m1.
  function automatic arb_state_t next_owner(input logic req0, input logic req1,
                                            input logic last);
    arb_state_t nxt;
    nxt = ARB_IDLE;
    if (req0 && req1) begin
      nxt = last ? ARB_OWN0 : ARB_OWN1;
    end else if (req0) begin
      nxt = ARB_OWN0;
    end else if (req1) begin
      nxt = ARB_OWN1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive unterminated strobe cycles of the owner.
// Ports: clk_i, reset_n (async, active-low); clear (ownership change);
// pending (owner cyc&stb with no slave termination this cycle);
// expire (high in the cycle the stall reaches TIMEOUT cycles).
module wb_watchdog #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic clear,
  input  logic pending,
  output logic expire
);

  localparam int unsigned LAST_CNT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CNT_WIDTH-1:0] cnt;

  // Expiry must land in the same cycle so the stalled strobe is terminated now.
  assign expire = (TIMEOUT != 0) && pending && (cnt == CNT_WIDTH'(LAST_CNT));

  // Stall counter; any termination, idle strobe or expiry restarts it.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || !pending || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wishbone_arbiter2.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant held for a
// whole bus cycle and a watchdog that forces err on stalled strobes.
// Ports: clk_i, reset_n (async, active-low); m0_req/m0_rsp and m1_req/m1_rsp
// are the master sides; s_req/s_rsp the shared slave side; gnt is the
// registered one-hot owner (01 = m0, 10 = m1, 00 = idle).
module wishbone_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n,
  input  wb_req_t                    m0_req,
  output wb_rsp_t                    m0_rsp,
  input  wb_req_t                    m1_req,
  output wb_rsp_t                    m1_rsp,
  output wb_req_t                    s_req,
  input  wb_rsp_t                    s_rsp,
  output logic [ARB_NUM_MASTERS-1:0] gnt
);

  arb_state_t                 state, state_nxt;
  logic                       last, last_nxt;
  logic [ARB_NUM_MASTERS-1:0] gnt_nxt;
  logic                       owned;
  logic                       pending;
  logic                       expire;
  logic                       wd_clear;
  wb_req_t                    own_req;
  wb_rsp_t                    own_rsp;

  // State, last-served owner and grant register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Next-state: the owner keeps the bus until it drops cyc, then hands over
  // directly to a waiting peer without an idle cycle.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ARB_IDLE: state_nxt = next_owner(m0_req.cyc, m1_req.cyc, last);
      ARB_OWN0: begin
        if (!m0_req.cyc) begin
          last_nxt  = 1'b0;
          state_nxt = m1_req.cyc ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        if (!m1_req.cyc) begin
          last_nxt  = 1'b1;
          state_nxt = m0_req.cyc ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    gnt_nxt = {state_nxt == ARB_OWN1, state_nxt == ARB_OWN0};
  end

  // Owner selection and stall detection feeding the watchdog.
  always_comb begin
    owned    = (state == ARB_OWN0) || (state == ARB_OWN1);
    own_req  = (state == ARB_OWN1) ? m1_req : m0_req;
    pending  = owned && own_req.cyc && own_req.stb &&
               !(s_rsp.ack || s_rsp.err || s_rsp.rty);
    wd_clear = (state_nxt != state);
  end

  wb_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_wdog (
    .clk_i  (clk_i),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .pending(pending),
    .expire (expire)
  );

  // Steering: nothing is forwarded in IDLE; on expiry the strobe is withdrawn
  // from the slave and the owner sees err instead of a response.
  always_comb begin
    s_req   = '0;
    m0_rsp  = '0;
    m1_rsp  = '0;
    own_rsp = s_rsp;
    if (expire) begin
      own_rsp.ack = 1'b0;
      own_rsp.err = 1'b1;
      own_rsp.rty = 1'b0;
    end
    if (owned) begin
      s_req = own_req;
      if (expire) begin
        s_req.stb = 1'b0;
      end
      if (state == ARB_OWN0) begin
        m0_rsp = own_rsp;
      end else begin
        m1_rsp = own_rsp;
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Self-checking bench for wishbone_arbiter2: arbitration vector table,
// directed multi-cycle scenarios and a randomized run against an owner model.
module tb_wishbone_arbiter2;
  import wb_arb_pkg::*;

  localparam int unsigned TO = 4;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  wb_req_t m0_req = '0, m1_req = '0;
  wb_rsp_t m0_rsp, m1_rsp, s_rsp, slv_rsp;
  wb_rsp_t rnd_rsp = '0;
  wb_req_t s_req;
  logic [1:0] gnt;
  logic    use_rnd = 1'b0;

  wb_rsp_t nw_m0_rsp, nw_m1_rsp;
  wb_req_t nw_s_req;
  wb_rsp_t nw_s_rsp;
  logic [1:0] nw_gnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wishbone_arbiter2 #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_n(rst_n),
    .m0_req(m0_req), .m0_rsp(m0_rsp),
    .m1_req(m1_req), .m1_rsp(m1_rsp),
    .s_req(s_req), .s_rsp(s_rsp), .gnt(gnt));

  wishbone_arbiter2 #(.TIMEOUT(0)) dut_nowd (
    .clk_i(clk), .reset_n(rst_n),
    .m0_req(m0_req), .m0_rsp(nw_m0_rsp),
    .m1_req(m1_req), .m1_rsp(nw_m1_rsp),
    .s_req(nw_s_req), .s_rsp(nw_s_rsp), .gnt(nw_gnt));

  assign nw_s_rsp = '0;

  // Register slave: acks slv_lat strobe cycles after the strobe appears
  // (0 = never), capturing write data when it decides to ack.
  int          slv_lat = 1;
  int          slv_wait;
  logic        slv_ack;
  logic        slv_fire;
  logic [31:0] slv_mem = 32'h0;

  always_comb begin
    slv_fire = s_req.cyc && s_req.stb && !slv_ack && (slv_lat != 0) &&
               (slv_wait == slv_lat - 1);
    slv_rsp     = '0;
    slv_rsp.ack = slv_ack;
    slv_rsp.dat = slv_mem;
    s_rsp       = use_rnd ? rnd_rsp : slv_rsp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_ack  <= 1'b0;
      slv_wait <= 0;
    end else begin
      slv_ack  <= slv_fire;
      slv_wait <= (slv_ack || !(s_req.cyc && s_req.stb)) ? 0 : slv_wait + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (slv_fire && s_req.we) slv_mem <= s_req.dat;
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    m0_req  = '0;
    m1_req  = '0;
    rnd_rsp = '0;
    use_rnd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int id, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ((id == 0) ? m0_rsp.ack : m1_rsp.ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  int done_cnt;

  // Issues n single-beat reads, releasing cyc for one cycle after each ack.
  task automatic master_run(input int id, input int n);
    bit got;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (id == 0) begin m0_req.cyc = 1'b1; m0_req.stb = 1'b1; m0_req.we = 1'b0; end
      else         begin m1_req.cyc = 1'b1; m1_req.stb = 1'b1; m1_req.we = 1'b0; end
      wait_ack(id, got);
      check($sformatf("t2_m%0d_ack_%0d", id, t), 128'(got), 128'(1));
      @(negedge clk);
      if (id == 0) begin m0_req.cyc = 1'b0; m0_req.stb = 1'b0; end
      else         begin m1_req.cyc = 1'b0; m1_req.stb = 1'b0; end
    end
    done_cnt++;
  endtask

  typedef struct {
    logic       c0;
    logic       c1;
    logic [1:0] exp_gnt;
  } arb_vec_t;

  // Reference model state for the randomized run.
  int   m_owner;  // 0 idle, 1 m0, 2 m1
  int   m_last;   // index of master served last
  int   m_stall;  // consecutive unterminated owner strobe cycles

  initial begin
    arb_vec_t   vecs[$];
    logic [1:0] gseq[$];
    logic [1:0] exp_seq[6];
    bit         got;
    int         idle_gaps, nonown_ack;
    logic [31:0] mem_before;

    vecs = '{
      '{1'b0, 1'b0, 2'b00}, '{1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 2'b01},
      '{1'b0, 1'b1, 2'b10}, '{1'b1, 1'b1, 2'b10}, '{1'b1, 1'b0, 2'b01},
      '{1'b0, 1'b0, 2'b00}, '{1'b1, 1'b1, 2'b10}, '{1'b0, 1'b0, 2'b00},
      '{1'b0, 1'b1, 2'b10}, '{1'b0, 1'b1, 2'b10}, '{1'b1, 1'b0, 2'b01},
      '{1'b0, 1'b0, 2'b00}, '{1'b1, 1'b0, 2'b01}, '{1'b0, 1'b0, 2'b00},
      '{1'b1, 1'b1, 2'b10}, '{1'b0, 1'b0, 2'b00}};
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // Reset held with both masters requesting, then m0 write of 0xA5.
    rst_n = 1'b0;
    slv_lat = 1;
    m0_req.cyc = 1'b1; m0_req.stb = 1'b1; m0_req.we = 1'b1;
    m0_req.adr = 32'h10; m0_req.sel = 4'hF; m0_req.dat = 32'h0000_00A5;
    m1_req.cyc = 1'b1; m1_req.stb = 1'b1; m1_req.we = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t1_rst_gnt", 128'(gnt), 128'(2'b00));
    check("t1_rst_scyc", 128'(s_req.cyc), 128'(0));
    check("t1_rst_m0ack", 128'(m0_rsp.ack), 128'(0));
    check("t1_rst_m1ack", 128'(m1_rsp.ack), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_gnt_first", 128'(gnt), 128'(2'b01));
    wait_ack(0, got);
    check("t1_m0_ack", 128'(got), 128'(1));
    check("t1_mem", 128'(slv_mem), 128'(32'h0000_00A5));
    @(negedge clk); m0_req = '0;
    @(posedge clk); #1;
    check("t1_handover_m1", 128'(gnt), 128'(2'b10));
    @(negedge clk); m1_req = '0;

    // Arbitration vector table (no strobes, grant only).
    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      m0_req.cyc = vecs[i].c0;
      m1_req.cyc = vecs[i].c1;
      @(posedge clk); #1;
      check($sformatf("tbl_gnt_%0d", i), 128'(gnt), 128'(vecs[i].exp_gnt));
    end

    // Tie round-robin with back-to-back handovers.
    do_reset();
    slv_lat = 1;
    done_cnt = 0; idle_gaps = 0; nonown_ack = 0;
    fork
      master_run(0, 3);
      master_run(1, 3);
      begin : mon
        logic [1:0] prev;
        prev = 2'b00;
        for (int i = 0; i < 200 && done_cnt < 2; i++) begin
          @(posedge clk); #1;
          if (gnt != prev && gnt != 2'b00) gseq.push_back(gnt);
          if (gnt == 2'b00 && gseq.size() > 0 && done_cnt < 2) idle_gaps++;
          if ((gnt == 2'b01 && m1_rsp.ack) || (gnt == 2'b10 && m0_rsp.ack)) nonown_ack++;
          prev = gnt;
        end
      end
    join
    check("t2_seq_len", 128'(gseq.size()), 128'(6));
    for (int i = 0; i < 6 && i < gseq.size(); i++)
      check($sformatf("t2_seq_%0d", i), 128'(gseq[i]), 128'(exp_seq[i]));
    check("t2_idle_gaps", 128'(idle_gaps), 128'(0));
    check("t2_nonowner_ack", 128'(nonown_ack), 128'(0));

    // Locked burst: m1 keeps cyc for 4 beats while m0 waits.
    do_reset();
    slv_lat = 1;
    @(negedge clk); m1_req.cyc = 1'b1;
    @(posedge clk); #1;
    check("t3_gnt_m1", 128'(gnt), 128'(2'b10));
    @(negedge clk); m0_req.cyc = 1'b1; m0_req.stb = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); m1_req.stb = 1'b1;
      wait_ack(1, got);
      check($sformatf("t3_ack_%0d", b), 128'(got), 128'(1));
      check($sformatf("t3_gnt_%0d", b), 128'(gnt), 128'(2'b10));
      check($sformatf("t3_m0ack_%0d", b), 128'(m0_rsp.ack), 128'(0));
      @(negedge clk); m1_req.stb = 1'b0;
    end
    @(negedge clk); m1_req.cyc = 1'b0;
    @(posedge clk); #1;
    check("t3_gnt_m0", 128'(gnt), 128'(2'b01));
    @(negedge clk); m0_req = '0;

    // Watchdog expiry on the 4th stalled strobe cycle.
    do_reset();
    slv_lat = 0;
    @(negedge clk); m0_req.cyc = 1'b1; m0_req.stb = 1'b1; m0_req.we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4_err_c%0d", k), 128'(m0_rsp.err), 128'(k == 4));
      check($sformatf("t4_sstb_c%0d", k), 128'(s_req.stb), 128'(k != 4));
      check($sformatf("t4_ack_c%0d", k), 128'(m0_rsp.ack), 128'(0));
    end
    @(negedge clk); m0_req = '0;

    // TIMEOUT=0 instance never terminates the same stall.
    do_reset();
    @(negedge clk); m0_req.cyc = 1'b1; m0_req.stb = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4n_err_c%0d", k), 128'(nw_m0_rsp.err), 128'(0));
      check($sformatf("t4n_sstb_c%0d", k), 128'(nw_s_req.stb), 128'(1));
    end
    check("t4n_gnt", 128'(nw_gnt), 128'(2'b01));
    check("t4n_m1rsp", 128'(nw_m1_rsp), 128'(0));
    @(negedge clk); m0_req = '0;

    // Slave ack colliding with expiry wins; the watchdog restarts afterwards.
    do_reset();
    slv_lat = 3;
    @(negedge clk);
    m0_req.cyc = 1'b1; m0_req.stb = 1'b1; m0_req.we = 1'b1; m0_req.dat = 32'h5A5A_0001;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("t5_ack_c%0d", k), 128'(m0_rsp.ack), 128'(k == 4));
      check($sformatf("t5_err_c%0d", k), 128'(m0_rsp.err), 128'(k == 8));
      if (k == 4) slv_lat = 0;
    end
    @(negedge clk); m0_req = '0;

    // Async reset between edges during a write.
    do_reset();
    slv_lat = 3;
    mem_before = slv_mem;
    @(negedge clk);
    m0_req.cyc = 1'b1; m0_req.stb = 1'b1; m0_req.we = 1'b1; m0_req.dat = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("t6_scyc_before", 128'(s_req.cyc), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_scyc_async", 128'(s_req.cyc), 128'(0));
    check("t6_sstb_async", 128'(s_req.stb), 128'(0));
    check("t6_gnt_async", 128'(gnt), 128'(2'b00));
    repeat (3) @(posedge clk); #1;
    check("t6_mem_kept", 128'(slv_mem), 128'(mem_before));
    @(negedge clk); m0_req = '0; rst_n = 1'b1;

    // Randomized run against the owner/stall model.
    do_reset();
    use_rnd = 1'b1;
    m_owner = 0; m_last = 1; m_stall = 0;
    for (int c = 0; c < 600; c++) begin
      wb_req_t ow, es;
      wb_rsp_t er, e0, e1;
      logic [1:0] eg;
      bit stalled, exp_exp, term;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) m0_req.cyc = ~m0_req.cyc;
      if ($urandom_range(0, 3) == 0) m0_req.stb = ~m0_req.stb;
      if ($urandom_range(0, 3) == 0) m1_req.cyc = ~m1_req.cyc;
      if ($urandom_range(0, 3) == 0) m1_req.stb = ~m1_req.stb;
      m0_req.we = 1'($urandom); m0_req.adr = $urandom; m0_req.dat = $urandom;
      m0_req.sel = WB_SEL_W'($urandom); m0_req.tgd = WB_TGD_W'($urandom);
      m1_req.we = 1'($urandom); m1_req.adr = $urandom; m1_req.dat = $urandom;
      m1_req.sel = WB_SEL_W'($urandom); m1_req.tgd = WB_TGD_W'($urandom);
      rnd_rsp.ack = ($urandom_range(0, 7) == 0);
      rnd_rsp.err = ($urandom_range(0, 15) == 0);
      rnd_rsp.rty = ($urandom_range(0, 15) == 0);
      rnd_rsp.dat = $urandom;
      rnd_rsp.tgd = WB_TGD_W'($urandom);
      #1;
      ow      = (m_owner == 2) ? m1_req : m0_req;
      term    = rnd_rsp.ack || rnd_rsp.err || rnd_rsp.rty;
      stalled = (m_owner != 0) && ow.cyc && ow.stb && !term;
      exp_exp = stalled && (m_stall == TO - 1);
      es = (m_owner != 0) ? ow : '0;
      if (exp_exp) es.stb = 1'b0;
      er = rnd_rsp;
      if (exp_exp) begin er.ack = 1'b0; er.err = 1'b1; er.rty = 1'b0; end
      e0 = (m_owner == 1) ? er : '0;
      e1 = (m_owner == 2) ? er : '0;
      eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      check($sformatf("rnd_gnt_%0d", c), 128'(gnt), 128'(eg));
      check($sformatf("rnd_sreq_%0d", c), 128'(s_req), 128'(es));
      check($sformatf("rnd_m0rsp_%0d", c), 128'(m0_rsp), 128'(e0));
      check($sformatf("rnd_m1rsp_%0d", c), 128'(m1_rsp), 128'(e1));
      m_stall = (stalled && !exp_exp) ? m_stall + 1 : 0;
      if (m_owner == 0) begin
        if (m0_req.cyc && m1_req.cyc) m_owner = (m_last == 0) ? 2 : 1;
        else if (m0_req.cyc)          m_owner = 1;
        else if (m1_req.cyc)          m_owner = 2;
      end else if (m_owner == 1 && !m0_req.cyc) begin
        m_last = 0; m_owner = m1_req.cyc ? 2 : 0;
      end else if (m_owner == 2 && !m1_req.cyc) begin
        m_last = 1; m_owner = m0_req.cyc ? 1 : 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
